// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with byte write mask, fixed response latency
// and valid/ready handshakes on both request and response channels.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_w_mask,
  input  logic        req_re,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  logic [31:0]           mem [0:DEPTH-1];
  state_t                state;
  logic [3:0]            cnt;
  logic                  is_read;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept;
  logic [31:0]           merged;

  // Byte offset and high address bits are intentionally ignored; addresses wrap.
  logic unused_addr;
  assign unused_addr = ^{req_addr[1:0], req_addr[31:DEPTH_LOG2+2]};

  assign idx       = req_addr[DEPTH_LOG2+1:2];
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  // Post-write view of the addressed word, so a combined write+read returns new data.
  always_comb begin
    merged = mem[idx];
    for (int i = 0; i < 4; i++) begin
      if (req_w_mask[i]) merged[8*i +: 8] = req_wdata[8*i +: 8];
    end
  end

  // NOTE: the storage array has no reset; clearing it would force it into flops.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (req_w_mask[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      is_read    <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            is_read <= req_re;
            if (req_re) resp_rdata <= merged;
            if (req_re || (req_w_mask != 4'b0000)) begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (is_read) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
